up3: RTL and testbench

UP3 -- requirements
Module: up3

---
 rtl/up3_if.sv | 26 ++
 rtl/up3.sv | 126 ++++++++++++
 tb/tb_up3.sv | 126 ++++++++++++
 3 files changed

// File: rtl/up3_if.sv
// Request/response bundle for the up3 fan-out learning block.
// master drives the requests and lane data, slave is the up3 side.
interface up3_if #(
  parameter int N = 9
);
  logic             oscillator;
  logic             fd_prop;
  logic             bk_prop;
  logic [N-1:0]     fin;
  logic [3*N-1:0]   bin;
  logic             fd_prop_done;
  logic             bk_prop_done;
  logic [3*N-1:0]   control_out;
  logic [3*N-1:0]   fout;
  logic [N-1:0]     bout;

  modport master (
    output oscillator, fd_prop, bk_prop, fin, bin,
    input  fd_prop_done, bk_prop_done, control_out, fout, bout
  );

  modport slave (
    input  oscillator, fd_prop, bk_prop, fin, bin,
    output fd_prop_done, bk_prop_done, control_out, fout, bout
  );
endinterface

// File: rtl/up3.sv
// up3: fans each input lane out to 3 XNOR-weighted outputs, with a majority
// backward path and an oscillator-gated weight flip, sequenced by a delay counter.

module up3_lane (
  input  logic       fin_b,
  input  logic [2:0] bin3,
  input  logic [2:0] w3,
  input  logic [2:0] fout3,
  output logic [2:0] fwd3,
  output logic       bwd_b,
  output logic [2:0] w_nxt3
);
  logic [2:0] agree;

  assign fwd3   = ~({3{fin_b}} ^ w3);
  assign agree  = ~(bin3 ^ w3);
  assign bwd_b  = (agree[0] & agree[1]) | (agree[0] & agree[2]) | (agree[1] & agree[2]);
  // Flip a weight wherever the target disagrees with the last forward result.
  assign w_nxt3 = w3 ^ (bin3 ^ fout3);
endmodule

module up3 #(
  parameter int N     = 9,
  parameter int DELAY = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  up3_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FWD, BWD} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(DELAY - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                latch_f, latch_b, fwd_fin, bwd_fin;
  logic [N-1:0]        fin_q;
  logic [N-1:0][2:0]   bin_q, w_q, fout_q;
  logic                osc_q;
  logic [N-1:0]        bout_q;
  logic                fd_done_q, bk_done_q;

  logic [N-1:0][2:0]   fwd_w, w_upd;
  logic [N-1:0]        bwd_w;

  for (genvar i = 0; i < N; i++) begin : g_lane
    up3_lane u_lane (
      .fin_b  (fin_q[i]),
      .bin3   (bin_q[i]),
      .w3     (w_q[i]),
      .fout3  (fout_q[i]),
      .fwd3   (fwd_w[i]),
      .bwd_b  (bwd_w[i]),
      .w_nxt3 (w_upd[i])
    );
  end

  // Forward wins a same-cycle collision; requests while busy are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_f = 1'b0;
    latch_b = 1'b0;
    fwd_fin = 1'b0;
    bwd_fin = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fd_prop) begin
          latch_f = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = FWD;
        end else if (bus.bk_prop) begin
          latch_b = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = BWD;
        end
      end
      FWD, BWD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          fwd_fin = (state_q == FWD);
          bwd_fin = (state_q == BWD);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      fin_q     <= '0;
      bin_q     <= '0;
      osc_q     <= 1'b0;
      w_q       <= '1;
      fout_q    <= '0;
      bout_q    <= '0;
      fd_done_q <= 1'b0;
      bk_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fd_done_q <= fwd_fin;
      bk_done_q <= bwd_fin;
      if (latch_f) fin_q <= bus.fin;
      if (latch_b) begin
        bin_q <= bus.bin;
        osc_q <= bus.oscillator;
      end
      if (fwd_fin) fout_q <= fwd_w;
      if (bwd_fin) begin
        bout_q <= bwd_w;
        if (osc_q) w_q <= w_upd;
      end
    end
  end

  assign bus.fd_prop_done = fd_done_q;
  assign bus.bk_prop_done = bk_done_q;
  assign bus.control_out  = w_q;
  assign bus.fout         = fout_q;
  assign bus.bout         = bout_q;
endmodule

// File: tb/tb_up3.sv
// Directed bench for up3 (N=3, DELAY=2): reset, fwd/bwd, weight update,
// collision and abort, with hand-computed expectations.
module tb_up3;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  up3_if #(.N(3)) bus ();

  up3 #(.N(3), .DELAY(2)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.oscillator = 1'b0;
    bus.fd_prop    = 1'b0;
    bus.bk_prop    = 1'b0;
    bus.fin        = '0;
    bus.bin        = '0;
    tick(); tick();
    chk("rst_w",    32'(bus.control_out), 32'h1FF);
    chk("rst_fout", 32'(bus.fout), 32'h0);
    chk("rst_bout", 32'(bus.bout), 32'h0);
    chk("rst_fd",   32'(bus.fd_prop_done), 32'h0);
    chk("rst_bk",   32'(bus.bk_prop_done), 32'h0);
    rst = 1'b0;

    // backward, no update
    bus.bin = 9'b111_000_110; bus.oscillator = 1'b0; bus.bk_prop = 1'b1;
    tick(); bus.bk_prop = 1'b0;
    chk("b0_done_t0", 32'(bus.bk_prop_done), 32'h0);
    tick();
    chk("b0_done_t1", 32'(bus.bk_prop_done), 32'h0);
    tick();
    chk("b0_done_t2", 32'(bus.bk_prop_done), 32'h1);
    chk("b0_fd_low",  32'(bus.fd_prop_done), 32'h0);
    chk("b0_bout",    32'(bus.bout), 32'h5);
    chk("b0_w",       32'(bus.control_out), 32'h1FF);
    tick();
    chk("b0_pulse",   32'(bus.bk_prop_done), 32'h0);

    // forward
    bus.fin = 3'b101; bus.fd_prop = 1'b1;
    tick(); bus.fd_prop = 1'b0;
    chk("f0_done_t0", 32'(bus.fd_prop_done), 32'h0);
    tick();
    chk("f0_done_t1", 32'(bus.fd_prop_done), 32'h0);
    chk("f0_fout_old", 32'(bus.fout), 32'h0);
    tick();
    chk("f0_done_t2", 32'(bus.fd_prop_done), 32'h1);
    chk("f0_fout",    32'(bus.fout), 32'h1C7);
    chk("f0_bout_hold", 32'(bus.bout), 32'h5);
    tick();
    chk("f0_pulse",   32'(bus.fd_prop_done), 32'h0);

    // backward with update
    bus.bin = 9'b111_000_110; bus.oscillator = 1'b1; bus.bk_prop = 1'b1;
    tick(); bus.bk_prop = 1'b0; bus.oscillator = 1'b0;
    tick();
    chk("b1_w_pre",   32'(bus.control_out), 32'h1FF);
    tick();
    chk("b1_done",    32'(bus.bk_prop_done), 32'h1);
    chk("b1_bout",    32'(bus.bout), 32'h5);
    chk("b1_w",       32'(bus.control_out), 32'h1FE);
    chk("b1_fout_hold", 32'(bus.fout), 32'h1C7);

    // forward with updated weights, issued right after the done pulse
    bus.fin = 3'b101; bus.fd_prop = 1'b1;
    tick(); bus.fd_prop = 1'b0;
    tick(); tick();
    chk("f1_done",    32'(bus.fd_prop_done), 32'h1);
    chk("f1_fout",    32'(bus.fout), 32'h1C6);
    tick();

    // collision, then bk_prop while busy
    bus.fin = 3'b010; bus.bin = 9'h0; bus.fd_prop = 1'b1; bus.bk_prop = 1'b1;
    tick(); bus.fd_prop = 1'b0; bus.bk_prop = 1'b1;
    tick(); bus.bk_prop = 1'b0;
    tick();
    chk("c_fd_done",  32'(bus.fd_prop_done), 32'h1);
    chk("c_bk_low",   32'(bus.bk_prop_done), 32'h0);
    chk("c_fout",     32'(bus.fout), 32'h039);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("c_no_bk",  32'(bus.bk_prop_done), 32'h0);
    end
    chk("c_bout_hold", 32'(bus.bout), 32'h5);

    // abort a forward with reset, then restart on the first free cycle
    bus.fin = 3'b101; bus.fd_prop = 1'b1;
    tick(); bus.fd_prop = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; bus.fd_prop = 1'b1;
    chk("a_fd_low",   32'(bus.fd_prop_done), 32'h0);
    chk("a_fout",     32'(bus.fout), 32'h0);
    chk("a_w",        32'(bus.control_out), 32'h1FF);
    tick(); bus.fd_prop = 1'b0;
    chk("a_fd_t0",    32'(bus.fd_prop_done), 32'h0);
    tick();
    chk("a_fd_t1",    32'(bus.fd_prop_done), 32'h0);
    tick();
    chk("a_fd_done",  32'(bus.fd_prop_done), 32'h1);
    chk("a_fout_new", 32'(bus.fout), 32'h1C7);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
